wormhole_rr_allocator: RTL and testbench

//  Output-port allocator for one router output (L, N, E, W or S); one instance per output port.

---
 rtl/router_defines_pkg.sv | 30 +++
 rtl/rr_pick.sv | 32 +++
 rtl/wormhole_rr_allocator.sv | 119 +++++++++++
 tb/tb_wormhole_rr_allocator.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_defines_pkg.sv
// Definitions shared by the router output-port allocators: flit type codes,
// port indices, allocator state encoding and a small pointer-wrap helper.
package router_defines;

    localparam int NPORT      = 5;
    localparam int FLIT_ID_W  = 3;
    localparam int PORT_IDX_W = 3;

    localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

    localparam logic [PORT_IDX_W-1:0] PORT_L = 3'd0;
    localparam logic [PORT_IDX_W-1:0] PORT_N = 3'd1;
    localparam logic [PORT_IDX_W-1:0] PORT_E = 3'd2;
    localparam logic [PORT_IDX_W-1:0] PORT_W = 3'd3;
    localparam logic [PORT_IDX_W-1:0] PORT_S = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } alloc_state_t;

    // Next round-robin start position after a win at p, wrapping at n.
    function automatic logic [PORT_IDX_W-1:0] wrap_inc(input logic [PORT_IDX_W-1:0] p,
                                                       input int n);
        return (int'(p) == n - 1) ? '0 : p + PORT_IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr,
// wrapping modulo NPORT.
module rr_pick
    import router_defines::*;
#(
    parameter int NPORT = 5
) (
    input  logic [NPORT-1:0]      cand,
    input  logic [PORT_IDX_W-1:0] ptr,
    output logic [NPORT-1:0]      onehot,
    output logic [PORT_IDX_W-1:0] idx,
    output logic                  any
);

    int pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int k = 0; k < NPORT; k++) begin
            pos = (int'(ptr) + k) % NPORT;
            if (!any && cand[pos]) begin
                any         = 1'b1;
                idx         = PORT_IDX_W'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wormhole_rr_allocator.sv
// Wormhole output-port allocator: round-robin on header flits, then locks the
// winner until its length count expires or a tail flit passes.
module wormhole_rr_allocator
    import router_defines::*;
#(
    parameter int NPORT     = 5,
    parameter int LEN_W     = 12,
    parameter int FLIT_ID_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT*FLIT_ID_W-1:0] flit_id,
    input  logic [NPORT*LEN_W-1:0] length,
    input  logic                   dcts,
    output logic [NPORT-1:0]       grant,
    output logic [NPORT-1:0]       owner,
    output logic                   busy,
    output logic [LEN_W-1:0]       remaining
);

    alloc_state_t          state, state_next;
    logic [NPORT-1:0]      owner_next;
    logic [PORT_IDX_W-1:0] ptr, ptr_next;
    logic [LEN_W-1:0]      remaining_next;

    logic [NPORT-1:0]      cand;
    logic [NPORT-1:0]      pick_onehot;
    logic [PORT_IDX_W-1:0] pick_idx;
    logic                  pick_any;
    logic [LEN_W-1:0]      pick_len;
    logic                  owner_req;
    logic                  owner_tail;
    logic                  xfer;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NPORT; i++) begin
            cand[i] = req[i] && (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_HEADER);
        end
    end

    rr_pick #(
        .NPORT(NPORT)
    ) u_pick (
        .cand  (cand),
        .ptr   (ptr),
        .onehot(pick_onehot),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Kept apart from the candidate build so the picker path is not a false loop.
    always_comb begin
        pick_len   = '0;
        owner_tail = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (pick_onehot[i]) begin
                pick_len = length[i*LEN_W +: LEN_W];
            end
            if (owner[i] && (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_TAIL)) begin
                owner_tail = 1'b1;
            end
        end
    end

    assign owner_req = |(req & owner);
    assign xfer      = (state == ST_LOCK) && dcts && owner_req;
    assign busy      = (state == ST_LOCK);

    always_comb begin
        state_next     = state;
        owner_next     = owner;
        ptr_next       = ptr;
        remaining_next = remaining;
        grant          = '0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next     = ST_LOCK;
                    owner_next     = pick_onehot;
                    remaining_next = pick_len;
                    ptr_next       = wrap_inc(pick_idx, NPORT);
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    grant = owner;
                    // A tail ends the packet even if the count says more flits follow.
                    if ((remaining == '0) || owner_tail) begin
                        state_next     = ST_IDLE;
                        owner_next     = '0;
                        remaining_next = '0;
                    end else begin
                        remaining_next = remaining - LEN_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            ptr       <= ptr_next;
            remaining <= remaining_next;
        end
    end

endmodule

// File: tb/tb_wormhole_rr_allocator.sv
// Bench for wormhole_rr_allocator: directed scenarios plus random traffic,
// every cycle compared against a packet-level reference model.
module tb_wormhole_rr_allocator;

    localparam int NP = 5;
    localparam int LW = 12;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req;
    logic [NP*3-1:0] flit_id;
    logic [NP*LW-1:0] length;
    logic            dcts;
    logic [NP-1:0]   grant;
    logic [NP-1:0]   owner;
    logic            busy;
    logic [LW-1:0]   remaining;

    int tests = 0;
    int fails = 0;

    bit m_lock;
    int m_own;
    int m_ptr;
    int m_rem;

    wormhole_rr_allocator dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .flit_id  (flit_id),
        .length   (length),
        .dcts     (dcts),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_lock = 1'b0;
        m_own  = 0;
        m_ptr  = 0;
        m_rem  = 0;
    endtask

    // One clock edge of the packet-level model, using the inputs currently applied.
    task automatic model_edge();
        bit found;
        found = 1'b0;
        if (!m_lock) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_ptr + k) % NP;
                if (!found && req[p] && flit_id[p*3 +: 3] == HDR) begin
                    found  = 1'b1;
                    m_lock = 1'b1;
                    m_own  = p;
                    m_rem  = int'(length[p*LW +: LW]);
                    m_ptr  = (p + 1) % NP;
                end
            end
        end else if (dcts && req[m_own]) begin
            if (m_rem == 0 || flit_id[m_own*3 +: 3] == TAIL) begin
                m_lock = 1'b0;
                m_own  = 0;
                m_rem  = 0;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic [4:0] g;
        logic [4:0] o;
        o = m_lock ? 5'(1 << m_own) : 5'd0;
        g = (m_lock && dcts && req[m_own]) ? o : 5'd0;
        return {g, o, m_lock, 12'(m_rem)};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {grant, owner, busy, remaining};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req     = '0;
        flit_id = '0;
        length  = '0;
        dcts    = 1'b0;
    endtask

    task automatic set_port(input int p, input bit r, input logic [2:0] f, input int l);
        req[p]              = r;
        flit_id[p*3 +: 3]   = f;
        length[p*LW +: LW]  = 12'(l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        set_port(0, 1'b1, HDR, 3);
        dcts = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({grant, owner, busy, remaining} !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=0", {grant, owner, busy, remaining});
        end
        rst = 1'b0;
        model_reset();
        clear_inputs();
        tick();
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_packet();
        int gcount;
        gcount = 0;
        clear_inputs();
        dcts = 1'b1;
        set_port(1, 1'b1, HDR, 3);
        for (int c = 0; c < 8; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL single c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (grant == 5'b00010) gcount++;
            if (c == 5) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL single_release busy=%b want=0", busy);
                end
            end
            tick();
            if (c == 0) flit_id[1*3 +: 3] = BODY;
        end
        tests++;
        if (gcount != 4) begin
            fails++;
            $display("FAIL single_grants got=%0d want=4", gcount);
        end
        // Pointer now at E: E beats N when both present headers.
        set_port(1, 1'b1, HDR, 0);
        set_port(2, 1'b1, HDR, 0);
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL single_ptr c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                tests++;
                if (owner !== 5'b00100) begin
                    fails++;
                    $display("FAIL single_ptr_owner got=%b want=00100", owner);
                end
            end
            tick();
            if (c == 1) req[2] = 1'b0;
            if (c == 3) req[1] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] seq[$];
        logic [4:0] g;
        do_reset();
        clear_inputs();
        dcts = 1'b1;
        set_port(0, 1'b1, HDR, 0);
        set_port(2, 1'b1, HDR, 0);
        set_port(4, 1'b1, HDR, 0);
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rr c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            g = grant;
            if (g != 5'd0) seq.push_back(g);
            tick();
            if (g != 5'd0) req = req & ~g;
            if (g == 5'b00100) set_port(0, 1'b1, HDR, 0);
        end
        tests++;
        if (seq.size() != 4) begin
            fails++;
            $display("FAIL rr_count got=%0d want=4", seq.size());
        end else if ({seq[0], seq[1], seq[2], seq[3]} !== {5'b00001, 5'b00100, 5'b10000, 5'b00001}) begin
            fails++;
            $display("FAIL rr_order got=%b %b %b %b want=00001 00100 10000 00001",
                     seq[0], seq[1], seq[2], seq[3]);
        end
    endtask

    task automatic test_stall();
        int gcount;
        gcount = 0;
        clear_inputs();
        set_port(3, 1'b1, HDR, 2);
        for (int c = 0; c < 10; c++) begin
            dcts = !(c >= 2 && c <= 4);
            #1;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL stall c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (c == 3) begin
                tests++;
                if (grant !== 5'd0 || remaining !== 12'd1) begin
                    fails++;
                    $display("FAIL stall_freeze grant=%b rem=%0d want grant=0 rem=1", grant, remaining);
                end
            end
            if (grant == 5'b01000) gcount++;
            tick();
            if (c == 0) flit_id[3*3 +: 3] = BODY;
            if (c == 6) req[3] = 1'b0;
        end
        tests++;
        if (gcount != 3) begin
            fails++;
            $display("FAIL stall_grants got=%0d want=3", gcount);
        end
    endtask

    task automatic test_early_tail();
        int gcount;
        gcount = 0;
        clear_inputs();
        dcts = 1'b1;
        set_port(4, 1'b1, HDR, 5);
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL tail c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (grant == 5'b10000) gcount++;
            if (c == 3) begin
                tests++;
                if (busy !== 1'b0 || remaining !== 12'd0) begin
                    fails++;
                    $display("FAIL tail_release busy=%b rem=%0d want busy=0 rem=0", busy, remaining);
                end
            end
            tick();
            if (c == 0) flit_id[4*3 +: 3] = BODY;
            if (c == 1) flit_id[4*3 +: 3] = TAIL;
            if (c == 2) req[4] = 1'b0;
        end
        tests++;
        if (gcount != 2) begin
            fails++;
            $display("FAIL tail_grants got=%0d want=2", gcount);
        end
    endtask

    task automatic test_interference();
        logic [4:0] seq[$];
        clear_inputs();
        dcts = 1'b1;
        set_port(0, 1'b1, HDR, 3);
        for (int c = 0; c < 9; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL interf c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (grant != 5'd0) seq.push_back(grant);
            tick();
            if (c == 0) begin
                flit_id[0*3 +: 3] = BODY;
                set_port(1, 1'b1, HDR, 0);
            end
            if (c == 4) req[0] = 1'b0;
            if (c == 6) req[1] = 1'b0;
        end
        tests++;
        if (seq.size() != 5) begin
            fails++;
            $display("FAIL interf_count got=%0d want=5", seq.size());
        end else if ({seq[0], seq[1], seq[2], seq[3], seq[4]} !==
                     {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00010}) begin
            fails++;
            $display("FAIL interf_order got=%b %b %b %b %b want=00001x4 00010",
                     seq[0], seq[1], seq[2], seq[3], seq[4]);
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_inputs();
        dcts = 1'b1;
        set_port(0, 1'b1, HDR, 10);
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rstmid c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
            if (c == 0) flit_id[0*3 +: 3] = BODY;
        end
        tests++;
        if (remaining !== 12'd7 || owner !== 5'b00001) begin
            fails++;
            $display("FAIL rstmid_pre rem=%0d owner=%b want rem=7 owner=00001", remaining, owner);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({grant, owner, busy, remaining} !== 23'd0) begin
            fails++;
            $display("FAIL rstmid_async got=%h want=0", {grant, owner, busy, remaining});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        dcts = 1'b1;
        set_port(0, 1'b1, HDR, 0);
        set_port(2, 1'b1, HDR, 0);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rstmid_after c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                tests++;
                if (grant !== 5'b00001) begin
                    fails++;
                    $display("FAIL rstmid_ptr grant=%b want=00001", grant);
                end
            end
            tick();
            if (c == 1) req[0] = 1'b0;
            if (c == 3) req[2] = 1'b0;
        end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                req[p] = ($urandom_range(0, 9) < 6);
                case ($urandom_range(0, 3))
                    0:       flit_id[p*3 +: 3] = HDR;
                    1:       flit_id[p*3 +: 3] = BODY;
                    2:       flit_id[p*3 +: 3] = TAIL;
                    default: flit_id[p*3 +: 3] = 3'($urandom_range(0, 7));
                endcase
                length[p*LW +: LW] = 12'($urandom_range(0, 4));
            end
            dcts = ($urandom_range(0, 4) != 0);
            #1;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stall();
        test_early_tail();
        test_interference();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
